// File: rtl/mux_2to1_13_pkg.sv
// Types and sizes shared by the BCH Euclidean datapath blocks.
package mux_2to1_13_pkg;
  localparam int BCH_SYM_W = 13;
  typedef logic [BCH_SYM_W-1:0] bch_sym_t;
endpackage

// File: rtl/mux_2to1_13_reg_stage.sv
// WIDTH-wide register with asynchronous active-low clear to RST_VAL.
import mux_2to1_13_pkg::*;

module mux_2to1_13_reg_stage #(
  parameter int               WIDTH   = BCH_SYM_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/mux_2to1_13.sv
// 13-bit 2:1 selector with a zero-latency output and a flopped copy of it.
import mux_2to1_13_pkg::*;

module mux_2to1_13 #(
  parameter int               WIDTH   = BCH_SYM_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  // Ternary keeps X propagation on an unknown sel in simulation.
  assign out = sel ? b : a;

  mux_2to1_13_reg_stage #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_reg (
    .clk   (clk),
    .reset (reset),
    .d     (out),
    .q     (out_q)
  );

endmodule

// File: tb/tb_mux_2to1_13.sv
// Self-checking bench for mux_2to1_13: reset, select, latency, hold loop, async reset, bit walk.
import mux_2to1_13_pkg::*;

module tb_mux_2to1_13;
  logic     clk = 1'b0;
  logic     reset = 1'b1;
  logic     sel = 1'b0;
  logic     loop_en = 1'b0;
  bch_sym_t a_tb = '0;
  bch_sym_t b = '0;
  bch_sym_t a, out, out_q;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected out_q values, pushed at stimulus, popped after the edge.
  bch_sym_t exp_q[$];
  bch_sym_t q_m = '0;

  assign a = loop_en ? out_q : a_tb;

  always #5 clk = ~clk;

  mux_2to1_13 dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .out   (out),
    .out_q (out_q)
  );

  // Drive inputs for one cycle, record the model's capture, then compare after the edge.
  task automatic cycle_push(input string name);
    bch_sym_t e;
    bch_sym_t got;
    e = sel ? b : a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    q_m = got;
    n_checks++;
    if (out_q !== got) begin
      n_fail++;
      $display("FAIL %s: out_q=%h expected %h", name, out_q, got);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    a_tb = 13'h1FFF; b = 13'h0AAA; sel = 1'b1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_q !== 13'h0000) begin n_fail++; $display("FAIL reset_async: out_q=%h expected 0000", out_q); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_q !== 13'h0000) begin n_fail++; $display("FAIL reset_hold: out_q=%h expected 0000", out_q); end
      n_checks++;
      if (out !== 13'h0AAA) begin n_fail++; $display("FAIL reset_out: out=%h expected 0aaa", out); end
    end
    q_m = '0;
  endtask

  task automatic test_select();
    @(negedge clk);
    reset = 1'b1;
    a_tb = 13'h1234; b = 13'h0F0F; sel = 1'b0;
    #1;
    n_checks++;
    if (out !== 13'h1234) begin n_fail++; $display("FAIL select_a: out=%h expected 1234", out); end
    sel = 1'b1;
    #1;
    n_checks++;
    if (out !== 13'h0F0F) begin n_fail++; $display("FAIL select_b: out=%h expected 0f0f", out); end
  endtask

  task automatic test_latency();
    bch_sym_t vals [3];
    vals[0] = 13'h0001; vals[1] = 13'h0002; vals[2] = 13'h1FFF;
    @(negedge clk);
    sel = 1'b1; b = 13'h0000;
    cycle_push("latency_prime");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b = vals[i];
      #1;
      n_checks++;
      if (out !== vals[i]) begin n_fail++; $display("FAIL latency_out: out=%h expected %h", out, vals[i]); end
      n_checks++;
      if (out_q !== q_m) begin n_fail++; $display("FAIL latency_early: out_q=%h expected %h", out_q, q_m); end
      cycle_push("latency_q");
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    loop_en = 1'b1;
    sel = 1'b1; b = 13'h15A5;
    cycle_push("hold_load");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sel = 1'b0;
      b = bch_sym_t'($urandom);
      cycle_push("hold_keep");
      n_checks++;
      if (out_q !== 13'h15A5) begin n_fail++; $display("FAIL hold_value: out_q=%h expected 15a5", out_q); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    sel = 1'b0; b = 13'h0777;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_q !== 13'h0000) begin n_fail++; $display("FAIL async_clear: out_q=%h expected 0000", out_q); end
    n_checks++;
    if (out !== 13'h0000) begin n_fail++; $display("FAIL async_out: out=%h expected 0000", out); end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_q !== 13'h0000) begin n_fail++; $display("FAIL async_hold: out_q=%h expected 0000", out_q); end
    q_m = '0;
    @(negedge clk);
    reset = 1'b1;
    sel = 1'b1; b = 13'h0003;
    cycle_push("async_release");
    @(negedge clk);
    sel = 1'b0; b = 13'h1F00;
    cycle_push("async_rehold");
    loop_en = 1'b0;
  endtask

  task automatic test_walk();
    bch_sym_t one;
    bch_sym_t e;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < BCH_SYM_W; i++) begin
        one = '0;
        one[i] = 1'b1;
        sel = (s == 1);
        a_tb = one; b = '0;
        #1;
        e = (s == 1) ? '0 : one;
        n_checks++;
        if (out !== e) begin n_fail++; $display("FAIL walk_a: sel=%0d bit=%0d out=%h expected %h", s, i, out, e); end
        a_tb = '0; b = one;
        #1;
        e = (s == 1) ? one : '0;
        n_checks++;
        if (out !== e) begin n_fail++; $display("FAIL walk_b: sel=%0d bit=%0d out=%h expected %h", s, i, out, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_latency();
    test_hold();
    test_async_reset();
    test_walk();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
